// File: rtl/alu_control_md_pkg.sv
// rtl/alu_control_md_pkg.sv - ALU control encodings, ALUOp/Funct codes, mult/div FSM states
// Purpose: shared constants for alu_control_md and muldiv_iter (package alu_pkg).
// Ports: none (package).
package alu_pkg;

  // ALU control words
  localparam logic [4:0] CTL_AND  = 5'b00000;
  localparam logic [4:0] CTL_OR   = 5'b00001;
  localparam logic [4:0] CTL_ADD  = 5'b00010;
  localparam logic [4:0] CTL_SUB  = 5'b00110;
  localparam logic [4:0] CTL_SLT  = 5'b00111;
  localparam logic [4:0] CTL_SLTU = 5'b01111;
  localparam logic [4:0] CTL_NOR  = 5'b01100;
  localparam logic [4:0] CTL_XOR  = 5'b01101;
  localparam logic [4:0] CTL_SLL  = 5'b10000;
  localparam logic [4:0] CTL_SRL  = 5'b11000;
  localparam logic [4:0] CTL_SRA  = 5'b11001;

  // Main-decoder ALU operation classes (ALUOp[2:0])
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;
  localparam logic [2:0] ALUOP_SLTU  = 3'b111;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} md_state_e;

  // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B; Funct[1] = divide, Funct[0] = unsigned
  function automatic logic is_md_funct(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

  // MFHI/MTHI/MFLO/MTLO occupy 0x10..0x13
  function automatic logic is_hilo_funct(input logic [5:0] f);
    return (f[5:2] == 4'b0100) || is_md_funct(f);
  endfunction

endpackage

// File: rtl/alu_control_md_if.sv
// rtl/alu_control_md_if.sv - EX-stage decode and mult/div signal bundle
// Purpose: groups the decoder/mult-div signals of alu_control_md.
// Ports: master drives valid_i, flush_i, ALUOp, Funct, op_a, op_b;
//        slave drives ALUCtl, shamt_sel, hilo_sel, hilo_rdata, md_busy, stall.
interface alu_control_md_if #(
  parameter int DATA_W   = 32,
  parameter int ALUCTL_W = 5
);
  logic                valid_i;
  logic                flush_i;
  logic [3:0]          ALUOp;
  logic [5:0]          Funct;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [ALUCTL_W-1:0] ALUCtl;
  logic                shamt_sel;
  logic                hilo_sel;
  logic [DATA_W-1:0]   hilo_rdata;
  logic                md_busy;
  logic                stall;

  modport master (
    output valid_i, flush_i, ALUOp, Funct, op_a, op_b,
    input  ALUCtl, shamt_sel, hilo_sel, hilo_rdata, md_busy, stall
  );

  modport slave (
    input  valid_i, flush_i, ALUOp, Funct, op_a, op_b,
    output ALUCtl, shamt_sel, hilo_sel, hilo_rdata, md_busy, stall
  );
endinterface

// File: rtl/alu_control_md_muldiv_iter.sv
// rtl/alu_control_md_muldiv_iter.sv - iterative multiply/divide unit with HI/LO registers
// Purpose: FSM (IDLE/MUL/DIV/FIX), iteration counter, shift-add multiplier,
//          restoring divider, HI/LO registers. Optional macro MD_EARLY_TERM_EN.
// Ports: clk, reset (async active-low); i_start/i_op/i_op_a/i_op_b start an op
//        (i_op[1]=divide, i_op[0]=unsigned); i_flush aborts; i_wr_hi/i_wr_lo/i_wdata
//        are MTHI/MTLO writes; o_hi/o_lo register contents; o_busy op in flight.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  input  logic              i_wr_hi,
  input  logic              i_wr_lo,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_busy
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  md_state_e             r_state, w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*DATA_W-1:0]   r_mcand;   // MUL: multiplicand shifted left; DIV: divisor in low half
  logic [DATA_W-1:0]     r_mplr;    // MUL: multiplier shifted right; DIV: dividend -> quotient
  logic [2*DATA_W-1:0]   r_acc;     // MUL: product; DIV: partial remainder in low half
  logic                  r_neg_res, r_neg_rem, r_is_div;
  logic [DATA_W-1:0]     r_hi, r_lo;

  logic                  w_load, w_write, w_mul_last;
  logic                  w_a_neg, w_b_neg;
  logic [DATA_W-1:0]     w_abs_a, w_abs_b;
  logic [DATA_W:0]       w_shift, w_trial;
  logic [2*DATA_W-1:0]   w_prod;
  logic [DATA_W-1:0]     w_quot, w_rem;

  assign w_a_neg = ~i_op[0] & i_op_a[DATA_W-1];
  assign w_b_neg = ~i_op[0] & i_op_b[DATA_W-1];
  assign w_abs_a = w_a_neg ? -i_op_a : i_op_a;
  assign w_abs_b = w_b_neg ? -i_op_b : i_op_b;

  // Restoring step: a non-negative trial sets the quotient bit. With a zero
  // divisor every bit is 1 and the remainder ends up equal to the dividend.
  assign w_shift = {r_acc[DATA_W-1:0], r_mplr[DATA_W-1]};
  assign w_trial = w_shift - {1'b0, r_mcand[DATA_W-1:0]};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quot = r_neg_res ? -r_mplr : r_mplr;
  assign w_rem  = r_neg_rem ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];

`ifdef MD_EARLY_TERM_EN
  // Stop once the multiplier bits still to be consumed are all zero
  assign w_mul_last = (r_cnt == LAST) || (r_mplr[DATA_W-1:1] == '0);
`else
  assign w_mul_last = (r_cnt == LAST);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_write = 1'b0;
    case (r_state)
      ST_IDLE: if (i_start) begin
        w_load = 1'b1;
        w_next = i_op[1] ? ST_DIV : ST_MUL;
      end
      ST_MUL:  if (w_mul_last) w_next = ST_FIX;
      ST_DIV:  if (r_cnt == LAST) w_next = ST_FIX;
      ST_FIX: begin
        w_write = 1'b1;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (i_flush) begin
      w_next  = ST_IDLE;
      w_load  = 1'b0;
      w_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_is_div  <= 1'b0;
    end else if (w_load) begin
      r_cnt     <= '0;
      r_mcand   <= {{DATA_W{1'b0}}, (i_op[1] ? w_abs_b : w_abs_a)};
      r_mplr    <= i_op[1] ? w_abs_a : w_abs_b;
      r_acc     <= '0;
      // Divide by zero keeps the all-ones quotient un-negated
      r_neg_res <= (w_a_neg ^ w_b_neg) & ~(i_op[1] & (i_op_b == '0));
      r_neg_rem <= w_a_neg;
      r_is_div  <= i_op[1];
    end else if (r_state == ST_MUL) begin
      r_cnt   <= r_cnt + 1'b1;
      r_acc   <= r_acc + (r_mplr[0] ? r_mcand : '0);
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
    end else if (r_state == ST_DIV) begin
      r_cnt  <= r_cnt + 1'b1;
      r_mplr <= {r_mplr[DATA_W-2:0], ~w_trial[DATA_W]};
      r_acc  <= {{DATA_W{1'b0}}, (w_trial[DATA_W] ? w_shift[DATA_W-1:0] : w_trial[DATA_W-1:0])};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_write) begin
      if (r_is_div) {r_hi, r_lo} <= {w_rem, w_quot};
      else          {r_hi, r_lo} <= w_prod;
    end else begin
      if (i_wr_hi) r_hi <= i_wdata;
      if (i_wr_lo) r_lo <= i_wdata;
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/alu_control_md.sv
// rtl/alu_control_md.sv - EX-stage ALU control decoder with iterative mult/div and HI/LO
// Purpose: decodes ALUOp/Funct into the ALU control word, handles HI/LO-class
//          instructions and raises stall while a mult/div blocks one.
//          Optional macro MD_EARLY_TERM_EN (early multiply termination).
// Ports: clk, reset (async active-low); bus (alu_control_md_if.slave):
//        in valid_i, flush_i, ALUOp, Funct, op_a, op_b;
//        out ALUCtl, shamt_sel, hilo_sel, hilo_rdata, md_busy, stall.
module alu_control_md
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ALUCTL_W = 5
) (
  input logic              clk,
  input logic              reset,
  alu_control_md_if.slave  bus
);
  logic [4:0]        w_ctl;
  logic              w_shamt;
  logic              w_hilo_cls, w_busy, w_stall, w_start, w_wr_hi, w_wr_lo;
  logic [DATA_W-1:0] w_hi, w_lo;
  logic              w_unused_aluop3;

  assign w_unused_aluop3 = bus.ALUOp[3];

  always_comb begin
    w_ctl   = CTL_ADD;
    w_shamt = 1'b0;
    case (bus.ALUOp[2:0])
      ALUOP_ADD:  w_ctl = CTL_ADD;
      ALUOP_SUB:  w_ctl = CTL_SUB;
      ALUOP_AND:  w_ctl = CTL_AND;
      ALUOP_SLT:  w_ctl = CTL_SLT;
      ALUOP_OR:   w_ctl = CTL_OR;
      ALUOP_XOR:  w_ctl = CTL_XOR;
      ALUOP_SLTU: w_ctl = CTL_SLTU;
      ALUOP_FUNCT: begin
        case (bus.Funct)
          FN_SLL:          w_ctl = CTL_SLL;
          FN_SRL:          w_ctl = CTL_SRL;
          FN_SRA:          w_ctl = CTL_SRA;
          FN_SLLV: begin   w_ctl = CTL_SLL; w_shamt = 1'b1; end
          FN_SRLV: begin   w_ctl = CTL_SRL; w_shamt = 1'b1; end
          FN_SRAV: begin   w_ctl = CTL_SRA; w_shamt = 1'b1; end
          FN_ADD, FN_ADDU: w_ctl = CTL_ADD;
          FN_SUB, FN_SUBU: w_ctl = CTL_SUB;
          FN_AND:          w_ctl = CTL_AND;
          FN_OR:           w_ctl = CTL_OR;
          FN_XOR:          w_ctl = CTL_XOR;
          FN_NOR:          w_ctl = CTL_NOR;
          FN_SLT:          w_ctl = CTL_SLT;
          FN_SLTU:         w_ctl = CTL_SLTU;
          default:         w_ctl = CTL_ADD;
        endcase
      end
      default: w_ctl = CTL_ADD;
    endcase
  end

  assign w_hilo_cls = bus.valid_i && (bus.ALUOp[2:0] == ALUOP_FUNCT) && is_hilo_funct(bus.Funct);
  assign w_stall    = w_hilo_cls & w_busy;
  // The unit only accepts in IDLE; !stall already implies that for md functs
  assign w_start    = w_hilo_cls & is_md_funct(bus.Funct) & ~w_stall & ~bus.flush_i;
  assign w_wr_hi    = w_hilo_cls & (bus.Funct == FN_MTHI) & ~w_stall;
  assign w_wr_lo    = w_hilo_cls & (bus.Funct == FN_MTLO) & ~w_stall;

  muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_op    (bus.Funct[1:0]),
    .i_flush (bus.flush_i),
    .i_op_a  (bus.op_a),
    .i_op_b  (bus.op_b),
    .i_wr_hi (w_wr_hi),
    .i_wr_lo (w_wr_lo),
    .i_wdata (bus.op_a),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_busy  (w_busy)
  );

  assign bus.ALUCtl     = ALUCTL_W'(w_ctl);
  assign bus.shamt_sel  = w_shamt;
  assign bus.hilo_sel   = w_hilo_cls & ((bus.Funct == FN_MFHI) | (bus.Funct == FN_MFLO));
  assign bus.hilo_rdata = (bus.Funct == FN_MFHI) ? w_hi : w_lo;
  assign bus.md_busy    = w_busy;
  assign bus.stall      = w_stall;

endmodule

// File: tb/tb_alu_control_md.sv
// tb/tb_alu_control_md.sv - self-checking bench for alu_control_md
module tb_alu_control_md;
  localparam int W = 32;
`ifdef MD_EARLY_TERM_EN
  localparam int LAT_SMALL = 2;
`else
  localparam int LAT_SMALL = W + 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_control_md_if #(.DATA_W(W), .ALUCTL_W(5)) bus_if ();
  alu_control_md #(.DATA_W(W), .ALUCTL_W(5)) dut (.clk(clk), .reset(rst_n), .bus(bus_if.slave));

  int vectors = 0;
  int errors  = 0;
  logic [2*W-1:0] exp_q[$];  // {HI, LO}
  logic [5:0]     dec_q[$];  // {shamt_sel, ALUCtl}

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus_if.valid_i = v; bus_if.ALUOp = op; bus_if.Funct = fn;
    bus_if.op_a = a; bus_if.op_b = b;
  endtask

  function automatic logic [2*W-1:0] md_model(input logic [5:0] fn, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa, sb;
    int ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ia = int'(a); ib = int'(b);
    case (fn)
      6'h18: return 64'(sa * sb);
      6'h19: return {32'b0, a} * {32'b0, b};
      6'h1A: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [5:0] dec_model(input logic [2:0] op, input logic [5:0] fn);
    case (op)
      3'b000: return {1'b0, 5'b00010};
      3'b001: return {1'b0, 5'b00110};
      3'b100: return {1'b0, 5'b00000};
      3'b101: return {1'b0, 5'b00111};
      3'b011: return {1'b0, 5'b00001};
      3'b110: return {1'b0, 5'b01101};
      3'b111: return {1'b0, 5'b01111};
      default: case (fn)
        6'h00: return {1'b0, 5'b10000};
        6'h04: return {1'b1, 5'b10000};
        6'h02: return {1'b0, 5'b11000};
        6'h06: return {1'b1, 5'b11000};
        6'h03: return {1'b0, 5'b11001};
        6'h07: return {1'b1, 5'b11001};
        6'h22, 6'h23: return {1'b0, 5'b00110};
        6'h24: return {1'b0, 5'b00000};
        6'h25: return {1'b0, 5'b00001};
        6'h26: return {1'b0, 5'b01101};
        6'h27: return {1'b0, 5'b01100};
        6'h2A: return {1'b0, 5'b00111};
        6'h2B: return {1'b0, 5'b01111};
        default: return {1'b0, 5'b00010};
      endcase
    endcase
  endfunction

  task automatic md_issue(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    drive(1'b1, 4'b0010, fn, a, b);
  endtask

  // Hold MFLO until it is no longer stalled, then read LO and HI
  task automatic md_collect(output int stalls, output logic [W-1:0] lo, output logic [W-1:0] hi,
                            output logic sel);
    stalls = 0;
    @(negedge clk);
    drive(1'b1, 4'b0010, 6'h12, '0, '0);
    #1;
    while (bus_if.stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    lo = bus_if.hilo_rdata;
    sel = bus_if.hilo_sel;
    bus_if.Funct = 6'h10;
    #1;
    hi = bus_if.hilo_rdata;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'b0010, 6'h12, '0, '0);
    bus_if.flush_i = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus_if.md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus_if.md_busy); end
    vectors++;
    if (bus_if.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus_if.stall); end
    vectors++;
    if (bus_if.hilo_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus_if.hilo_rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
  endtask

  task automatic test_decode();
    logic [5:0] fns [30];
    logic [5:0] got, e;
    fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h10, 6'h11, 6'h12, 6'h13,
            6'h18, 6'h19, 6'h1A, 6'h1B, 6'h3F, 6'h01, 6'h05, 6'h08, 6'h2C, 6'h30};
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(1'b0, 4'b0010, fns[i], '0, '0);
      dec_q.push_back(dec_model(3'b010, fns[i]));
      #1;
      got = {bus_if.shamt_sel, bus_if.ALUCtl};
      e = dec_q.pop_front();
      vectors++;
      if (got !== e) begin errors++; $display("FAIL decode_funct %h got %b exp %b", fns[i], got, e); end
    end
    for (int op = 0; op < 16; op++) begin
      @(negedge clk);
      drive(1'b0, 4'(op), 6'($urandom_range(0, 63)), '0, '0);
      dec_q.push_back(dec_model(3'(op), bus_if.Funct));
      #1;
      got = {bus_if.shamt_sel, bus_if.ALUCtl};
      e = dec_q.pop_front();
      vectors++;
      if (got !== e) begin errors++; $display("FAIL decode_aluop %h got %b exp %b", op, got, e); end
    end
  endtask

  task automatic run_md(input string name, input logic [5:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat);
    int n;
    logic [W-1:0] lo, hi;
    logic sel;
    logic [2*W-1:0] e;
    md_issue(fn, a, b);
    exp_q.push_back(md_model(fn, a, b));
    md_collect(n, lo, hi, sel);
    e = exp_q.pop_front();
    vectors++;
    if (n !== lat) begin errors++; $display("FAIL %s_stall got %0d exp %0d", name, n, lat); end
    vectors++;
    if (lo !== e[W-1:0]) begin errors++; $display("FAIL %s_lo got %h exp %h", name, lo, e[W-1:0]); end
    vectors++;
    if (hi !== e[2*W-1:W]) begin errors++; $display("FAIL %s_hi got %h exp %h", name, hi, e[2*W-1:W]); end
    vectors++;
    if (sel !== 1'b1) begin errors++; $display("FAIL %s_hilo_sel got %b exp 1", name, sel); end
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
  endtask

  task automatic test_mult();
    run_md("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'd7, W + 1);
    run_md("multu_big", 6'h19, 32'hDEAD_BEEF, 32'hF00D_CAFE, W + 1);
    run_md("mult_negneg", 6'h18, 32'h8000_0000, 32'hFFFF_FFFF, W + 1);
  endtask

  task automatic test_div();
    run_md("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'd2, W + 1);
    run_md("divu_zero", 6'h1B, 32'd7, 32'd0, W + 1);
    run_md("div_minneg1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, W + 1);
    run_md("div_pos_neg", 6'h1A, 32'd100, 32'hFFFF_FFF9, W + 1);
    run_md("divu_big", 6'h1B, 32'hFFFF_FFFF, 32'd10, W + 1);
  endtask

  task automatic test_early_term();
    run_md("multu_5x1", 6'h19, 32'd5, 32'd1, LAT_SMALL);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [W-1:0] lo, hi;
    logic sel;
    logic [2*W-1:0] e;
    md_issue(6'h18, 32'd3, 32'd4);
    @(negedge clk);
    drive(1'b1, 4'b0010, 6'h1B, 32'd100, 32'd7);
    exp_q.push_back(md_model(6'h1B, 32'd100, 32'd7));
    n = 0;
    #1;
    while (bus_if.stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    vectors++;
    if (n !== W + 1) begin errors++; $display("FAIL b2b_hold got %0d exp %0d", n, W + 1); end
    md_collect(n, lo, hi, sel);
    e = exp_q.pop_front();
    vectors++;
    if (n !== W + 1) begin errors++; $display("FAIL b2b_stall got %0d exp %0d", n, W + 1); end
    vectors++;
    if ({hi, lo} !== e) begin errors++; $display("FAIL b2b_result got %h exp %h", {hi, lo}, e); end
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
  endtask

  task automatic test_flush();
    int n;
    logic [W-1:0] lo, hi;
    logic sel;
    logic [2*W-1:0] e;
    md_issue(6'h11, 32'h1111_1111, '0);
    md_issue(6'h13, 32'h2222_2222, '0);
    exp_q.push_back({32'h1111_1111, 32'h2222_2222});
    // flush in the same cycle as a start must win
    md_issue(6'h19, 32'd9, 32'd9);
    bus_if.flush_i = 1'b1;
    @(negedge clk);
    bus_if.flush_i = 1'b0;
    #1;
    vectors++;
    if (bus_if.md_busy !== 1'b0) begin errors++; $display("FAIL flush_start got %b exp 0", bus_if.md_busy); end
    md_issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
    repeat (8) @(negedge clk);
    #1;
    vectors++;
    if (bus_if.md_busy !== 1'b1) begin errors++; $display("FAIL flush_inflight got %b exp 1", bus_if.md_busy); end
    bus_if.flush_i = 1'b1;
    @(negedge clk);
    bus_if.flush_i = 1'b0;
    #1;
    vectors++;
    if (bus_if.md_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", bus_if.md_busy); end
    md_collect(n, lo, hi, sel);
    e = exp_q.pop_front();
    vectors++;
    if (n !== 0) begin errors++; $display("FAIL flush_stall got %0d exp 0", n); end
    vectors++;
    if ({hi, lo} !== e) begin errors++; $display("FAIL flush_hilo got %h exp %h", {hi, lo}, e); end
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
  endtask

  task automatic test_reset_mid_div();
    md_issue(6'h1A, 32'd1000, 32'd3);
    @(negedge clk);
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if (bus_if.md_busy !== 1'b1) begin errors++; $display("FAIL mid_div_busy got %b exp 1", bus_if.md_busy); end
    @(negedge clk);
    drive(1'b1, 4'b0010, 6'h12, '0, '0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus_if.md_busy !== 1'b0) begin errors++; $display("FAIL rst_div_busy got %b exp 0", bus_if.md_busy); end
    vectors++;
    if (bus_if.stall !== 1'b0) begin errors++; $display("FAIL rst_div_stall got %b exp 0", bus_if.stall); end
    vectors++;
    if (bus_if.hilo_rdata !== '0) begin errors++; $display("FAIL rst_div_lo got %h exp 0", bus_if.hilo_rdata); end
    bus_if.Funct = 6'h10;
    #1;
    vectors++;
    if (bus_if.hilo_rdata !== '0) begin errors++; $display("FAIL rst_div_hi got %h exp 0", bus_if.hilo_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
  endtask

  initial begin
    bus_if.flush_i = 1'b0;
    drive(1'b0, 4'b0000, 6'h00, '0, '0);
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_early_term();
    test_back_to_back();
    test_flush();
    test_reset_mid_div();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_control_md.md
# alu_control_md

Parametrised successor to the EX-stage ALU control decoder: decodes ALUOp/Funct into the 5-bit ALU control word and adds a sequential multiply/divide unit with HI/LO registers. Sits in the EX stage beside the ALU; raises a stall to the hazard unit while a multi-cycle operation blocks a dependent instruction.

## Interface
- DATA_W, 32: operand and HI/LO width (even, ≥8)
- ALUCTL_W, 5: ALU control word width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- valid_i  in  1  instruction in EX is valid
- flush_i  in  1  abort in-flight mult/div
- ALUOp  in  4  main-decoder ALU operation class
- Funct  in  6  R-type function field
- op_a  in  DATA_W  rs value
- op_b  in  DATA_W  rt value
- ALUCtl  out  ALUCTL_W  ALU control word (combinational)
- shamt_sel  out  1  1 = shift amount from op_a[4:0] (variable shift)
- hilo_sel  out  1  1 = EX result from hilo_rdata
- hilo_rdata  out  DATA_W  HI (MFHI) or LO (MFLO)
- md_busy  out  1  mult/div in progress
- stall  out  1  hold pipeline this cycle

## Operation
- ALUOp[2:0]: 000 ADD, 001 SUB, 100 AND, 101 SLT, 010 Funct-decoded, 011 OR, 110 XOR, 111 SLTU; ALUOp[3] reserved, ignored.
- Encodings: AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, SLTU 01111, NOR 01100, XOR 01101, SLL 10000, SRL 11000, SRA 11001.
- Funct: 00/04 SLL, 02/06 SRL, 03/07 SRA (04/06/07 set shamt_sel), 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU; unknown → ADD.
- HI/LO funct (only with ALUOp=010 and valid_i): 10 MFHI, 12 MFLO (hilo_sel=1), 11 MTHI, 13 MTLO, 18 MULT, 19 MULTU, 1A DIV, 1B DIVU.
- FSM states IDLE, MUL, DIV, FIX.
  - IDLE: valid mult/div and !stall → capture |op_a|, |op_b| (signed ops) or raw, record signs, counter=0; → MUL or DIV.
  - MUL: shift-add, one multiplier bit per cycle; DIV: restoring, one quotient bit per cycle; after DATA_W iterations → FIX.
  - FIX: negate product / quotient / remainder per signs (remainder takes dividend sign); write {HI,LO}; → IDLE.
- MULT/U: {HI,LO} = 2·DATA_W-bit product. DIV/U: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = op_a as captured; no exception. Signed min ÷ −1: LO = 0x8000_0000, HI = 0 (DATA_W=32).
- MTHI/MTLO write op_a at the clock edge when !stall; ignored while busy (stalled).
- stall = valid_i & (HI/LO-class funct) & md_busy.
- flush_i: any state → IDLE next edge; HI/LO unchanged. flush_i overrides a same-cycle start.
- Reset: state IDLE, counter 0, HI = LO = 0, md_busy = 0; outputs consequently stall = 0, hilo_rdata = 0.

## Timing
- Decode outputs (ALUCtl, shamt_sel, hilo_sel, hilo_rdata, stall) combinational, zero latency.
- Start accepted at edge E0; md_busy high from E0 until edge E0+DATA_W+1 (FIX writes HI/LO at that edge); latency DATA_W+1 cycles.
- An MFHI/MFLO in the cycle after md_busy falls reads the new value with no stall.
- Back-to-back mult/div: second stalls until IDLE, then starts that cycle.

## Configuration
- MD_EARLY_TERM_EN defined: MUL transitions to FIX as soon as the remaining unsigned multiplier bits are all zero (minimum 1 iteration); DIV unaffected. Latency for MULT by 0 or 1: 2 cycles.
- Undefined: fixed DATA_W iterations for all ops.

## Structure
- Package alu_pkg: ALUCtl encodings, ALUOp codes, Funct constants, FSM state enum.
- Sub-module muldiv_iter: FSM, counter, iterative datapath, HI/LO registers; alu_control_md holds decode and stall logic.

## Test plan
- ALUOp=010 sweep all listed Funct codes plus 3F → listed ALUCtl/shamt_sel; 3F → 00010.
- MULT op_a=−3, op_b=7 → stall on MFLO for 33 cycles, then HI=FFFF_FFFF, LO=FFFF_FFEB.
- DIV op_a=−7, op_b=2 → LO=FFFF_FFFD, HI=FFFF_FFFF; DIVU 7/0 → LO=FFFF_FFFF, HI=7.
- MULTU in flight, flush_i at cycle 10 → md_busy low next edge, HI/LO keep prior MTHI/MTLO values.
- reset asserted mid-DIV → immediate IDLE, HI=LO=0, stall=0; MULTU 5×1 with MD_EARLY_TERM_EN → busy 2 cycles, LO=5.
